audio_path_sched: RTL and testbench
===================================

AUDIO_PATH_SCHED -- requirements
Module: audio_path_sched

Interface
REQ-001 Parameter: AMPLITUDE, 32'd10000000, tone magnitude; square wave swings to +AMPLITUDE or -AMPLITUDE.
REQ-002 Parameter: BASE_HALF, 15'd3000, low field of the tone half-period.
REQ-003 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 mode  in  2  source select: 00 passthrough, 01 gated (input chopped by tone), 10 tone only, 11 mute.
REQ-006 period_sel  in  4  tone pitch; half-period = {period_sel, BASE_HALF} cycles (19 bits); 0 disables the tone.
REQ-007 audio_in_available  in  1  codec input FIFO non-empty.
REQ-008 left_channel_audio_in / right_channel_audio_in  in  32 each  input FIFO head sample.
REQ-009 audio_out_allowed  in  1  codec output FIFO has space.
REQ-010 read_audio_in  out  1  one-cycle pop of the input FIFO.
REQ-011 write_audio_out  out  1  one-cycle push to the output FIFO.
REQ-012 left_channel_audio_out / right_channel_audio_out  out  32 each  registered sample, valid while write_audio_out=1.
REQ-013 xfer_count  out  16  count of write_audio_out pulses.
REQ-014 tone_level  out  1  current square-wave phase (snd).

Function
REQ-015 The FSM SHALL have states IDLE, XFER and HOLD.
REQ-016 IDLE SHALL latch mode into mode_q when its exit condition is met.
REQ-017 IDLE exit condition, modes 00/01: audio_in_available=1 and audio_out_allowed=1.
REQ-018 IDLE exit condition, modes 10/11: audio_out_allowed=1.
REQ-019 On IDLE exit the block SHALL register the output sample and move to XFER.
REQ-020 Sample per channel: 00 -> input; 01 -> 0 if snd else input; 10 -> +AMPLITUDE if snd else -AMPLITUDE (32-bit two's complement); 11 -> 0.
REQ-021 XFER SHALL assert write_audio_out for exactly one cycle, then go to HOLD.
REQ-022 In XFER, read_audio_in SHALL be 1 when mode_q is 00/01.
REQ-023 In XFER with mode_q 10/11, read_audio_in SHALL be 1 iff audio_in_available=1, draining the input without using the data.
REQ-024 HOLD SHALL last exactly one cycle with both strobes low, to absorb FIFO flag latency, then return to IDLE.
REQ-025 Minimum transfer interval SHALL be 3 cycles; latency from condition true in IDLE to write_audio_out SHALL be 1 cycle.
REQ-026 read_audio_in and write_audio_out SHALL be low outside XFER.
REQ-027 A mode change outside IDLE SHALL NOT affect the transfer in flight.
REQ-028 Outputs SHALL hold their last value outside XFER.
REQ-029 xfer_count SHALL increment on every XFER cycle and wrap 16'hFFFF -> 0.
REQ-030 Tone counter tone_cnt (19 bits) SHALL increment each cycle.
REQ-031 When tone_cnt >= half-period, tone_cnt SHALL clear and snd SHALL toggle; >= covers a period reduced below the current count.
REQ-032 When period_sel=0, tone_cnt and snd SHALL be held at 0.
REQ-033 The tone SHALL run independently of FSM state.

Reset
REQ-034 resetn=0 SHALL immediately force: state IDLE, mode_q 00, tone_cnt 0, snd 0, xfer_count 0.
REQ-035 resetn=0 SHALL immediately force both strobes 0 and both sample outputs 0.
REQ-036 Reset asserted during XFER SHALL abort the strobe in that cycle.
REQ-037 After reset release, the first transfer SHALL occur no earlier than the second rising edge.

Structure
REQ-038 Shared package audio_pkg SHALL hold the mode encodings, the FSM state type, and the AMPLITUDE and BASE_HALF defaults.
REQ-039 The tone counter and snd SHALL be in sub-module tone_gen (ports CLOCK_50, resetn, period_sel, snd); the FSM and datapath stay in audio_path_sched.

Verification
REQ-040 Mode 00, available=allowed=1 constantly, input L=32'h1234, R=32'h5678 -> write every 3 cycles, outputs 1234/5678, read_audio_in coincident with each write.
REQ-041 Mode 10, period_sel=1 -> snd toggles every 35769 cycles; outputs alternate 32'd10000000 and 32'hFF676980; input drained only while available=1.
REQ-042 Mode 00 with allowed=0 for 100 cycles, available=1 -> no strobes; write occurs 1 cycle after allowed rises.
REQ-043 Mode switched 00 -> 11 in the XFER cycle -> that write carries input data; the next write carries 0.
REQ-044 xfer_count preset to 16'hFFFE by running transfers, then two more transfers -> 16'hFFFF, then 16'h0000.
REQ-045 resetn pulsed low mid-XFER, and period_sel changed 15 -> 1 while tone_cnt > 35768 -> strobes drop immediately; tone toggles on the next cycle after the change.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared encodings and defaults for the audio path scheduler and its tone generator.
package audio_pkg;

  typedef enum logic [1:0] {
    ModePass  = 2'b00,
    ModeGated = 2'b01,
    ModeTone  = 2'b10,
    ModeMute  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StXfer = 2'b01,
    StHold = 2'b10
  } state_e;

  localparam logic [31:0] AmplitudeDefault = 32'd10000000;
  localparam logic [14:0] BaseHalfDefault  = 15'd3000;

  // Modes that consume the codec input sample and therefore need the input FIFO non-empty.
  function automatic logic mode_uses_input(input mode_e m);
    return (m == ModePass) || (m == ModeGated);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone source: toggles snd every {period_sel, BASE_HALF}+1 cycles, idle when period_sel=0.
module tone_gen
  import audio_pkg::*;
#(
  parameter logic [14:0] BASE_HALF = BaseHalfDefault
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [3:0] period_sel,
  output logic       snd
);

  logic [18:0] half_period;
  logic [18:0] cnt_q, cnt_d;
  logic        snd_q, snd_d;

  assign half_period = {period_sel, BASE_HALF};

  // >= rather than == so a pitch change to a shorter period wraps at once.
  always_comb begin
    cnt_d = cnt_q + 19'd1;
    snd_d = snd_q;
    if (period_sel == 4'd0) begin
      cnt_d = '0;
      snd_d = 1'b0;
    end else if (cnt_q >= half_period) begin
      cnt_d = '0;
      snd_d = ~snd_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      snd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      snd_q <= snd_d;
    end
  end

  assign snd = snd_q;

endmodule

// File: rtl/audio_path_sched.sv
// Codec FIFO scheduler: moves one stereo sample per IDLE->XFER->HOLD pass, sourced per mode.
module audio_path_sched
  import audio_pkg::*;
#(
  parameter logic [31:0] AMPLITUDE = AmplitudeDefault,
  parameter logic [14:0] BASE_HALF = BaseHalfDefault
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [1:0]  mode,
  input  logic [3:0]  period_sel,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  input  logic        audio_out_allowed,
  output logic        read_audio_in,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic [15:0] xfer_count,
  output logic        tone_level
);

  state_e      state_q;
  mode_e       mode_q;
  mode_e       mode_in;
  logic        init_q;
  logic        write_q;
  logic [31:0] left_q, right_q;
  logic [15:0] count_q;
  logic        snd;
  logic        go;

  tone_gen #(
    .BASE_HALF (BASE_HALF)
  ) u_tone_gen (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .period_sel (period_sel),
    .snd        (snd)
  );

  function automatic logic [31:0] pick_sample(input mode_e m, input logic s,
                                              input logic [31:0] din);
    logic [31:0] res;
    res = '0;
    unique case (m)
      ModePass:  res = din;
      ModeGated: res = s ? 32'd0 : din;
      ModeTone:  res = s ? AMPLITUDE : (32'd0 - AMPLITUDE);
      ModeMute:  res = 32'd0;
      default:   res = 32'd0;
    endcase
    return res;
  endfunction

  assign mode_in = mode_e'(mode);
  assign go      = audio_out_allowed && (!mode_uses_input(mode_in) || audio_in_available);

  // init_q holds off the first transfer until the second edge after reset release.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      mode_q  <= ModePass;
      init_q  <= 1'b0;
      write_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      init_q  <= 1'b1;
      write_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (init_q && go) begin
            mode_q  <= mode_in;
            left_q  <= pick_sample(mode_in, snd, left_channel_audio_in);
            right_q <= pick_sample(mode_in, snd, right_channel_audio_in);
            write_q <= 1'b1;
            state_q <= StXfer;
          end
        end
        StXfer:  state_q <= StHold;
        StHold:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (state_q == StXfer) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Tone/mute transfers still pop the input FIFO when it has data so it never backs up.
  assign read_audio_in = (state_q == StXfer) && (mode_uses_input(mode_q) || audio_in_available);

  assign write_audio_out         = write_q;
  assign left_channel_audio_out  = left_q;
  assign right_channel_audio_out = right_q;
  assign xfer_count              = count_q;
  assign tone_level              = snd;

endmodule

// File: tb/tb_audio_path_sched.sv
// Directed bench for audio_path_sched with hand-computed expectations.
module tb_audio_path_sched;

  localparam logic [31:0] Amp    = 32'd10000000;
  localparam logic [31:0] AmpNeg = 32'hFF676980;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [1:0]  mode;
  logic [3:0]  period_sel;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in, right_channel_audio_in;
  logic        audio_out_allowed;
  logic        read_audio_in, write_audio_out;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic [15:0] xfer_count;
  logic        tone_level;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rel_cyc;
  int          toggle_cyc;
  logic [15:0] mon_cnt;
  logic        saw_strobe;
  logic        got_write;

  audio_path_sched dut (
    .CLOCK_50                (CLOCK_50),
    .resetn                  (resetn),
    .mode                    (mode),
    .period_sel              (period_sel),
    .audio_in_available      (audio_in_available),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .audio_out_allowed       (audio_out_allowed),
    .read_audio_in           (read_audio_in),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .xfer_count              (xfer_count),
    .tone_level              (tone_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Independent tally of write strobes, used as the expected transfer count.
  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) mon_cnt <= '0;
    else if (write_audio_out) mon_cnt <= mon_cnt + 16'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      cyc++;
    end
    #1;
  endtask

  task automatic wait_write();
    got_write = 1'b0;
    for (int i = 0; i < 12 && !got_write; i++) begin
      tick(1);
      got_write = write_audio_out;
    end
    check_eq("wait_write_seen", {31'd0, got_write}, 32'd1);
  endtask

  // Drain to IDLE, then run one transfer in the requested mode.
  task automatic next_write(input logic [1:0] m);
    audio_out_allowed = 1'b0;
    tick(3);
    mode = m;
    audio_out_allowed = 1'b1;
    wait_write();
  endtask

  initial begin
    resetn = 1'b0;
    mode = 2'b00;
    period_sel = 4'd15;
    audio_in_available = 1'b0;
    audio_out_allowed = 1'b0;
    left_channel_audio_in = 32'h1234;
    right_channel_audio_in = 32'h5678;
    #12;
    check_eq("rst_write", {31'd0, write_audio_out}, 32'd0);
    check_eq("rst_read", {31'd0, read_audio_in}, 32'd0);
    check_eq("rst_left", left_channel_audio_out, 32'd0);
    check_eq("rst_right", right_channel_audio_out, 32'd0);
    check_eq("rst_count", {16'd0, xfer_count}, 32'd0);
    check_eq("rst_tone", {31'd0, tone_level}, 32'd0);

    // Passthrough, both flags high: first write on edge 2, then every 3 cycles.
    tick(1);
    resetn = 1'b1;
    audio_in_available = 1'b1;
    audio_out_allowed = 1'b1;
    rel_cyc = cyc;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      check_eq($sformatf("pass_write_e%0d", i), {31'd0, write_audio_out},
               {31'd0, (i % 3) == 2});
      check_eq($sformatf("pass_read_e%0d", i), {31'd0, read_audio_in},
               {31'd0, (i % 3) == 2});
      if ((i % 3) == 2) begin
        check_eq("pass_left", left_channel_audio_out, 32'h1234);
        check_eq("pass_right", right_channel_audio_out, 32'h5678);
      end
    end
    check_eq("pass_count", {16'd0, xfer_count}, 32'd3);

    // Output FIFO full for 100 cycles: no strobes; write one cycle after it frees.
    audio_out_allowed = 1'b0;
    saw_strobe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (write_audio_out || read_audio_in) saw_strobe = 1'b1;
    end
    check_eq("blocked_no_strobe", {31'd0, saw_strobe}, 32'd0);
    audio_out_allowed = 1'b1;
    tick(1);
    check_eq("unblock_latency", {31'd0, write_audio_out}, 32'd1);

    // Switch to mute during XFER: this write keeps input data, next carries 0.
    mode = 2'b11;
    #1;
    check_eq("midxfer_read", {31'd0, read_audio_in}, 32'd1);
    check_eq("midxfer_left", left_channel_audio_out, 32'h1234);
    tick(3);
    check_eq("mute_write", {31'd0, write_audio_out}, 32'd1);
    check_eq("mute_left", left_channel_audio_out, 32'd0);
    check_eq("mute_right", right_channel_audio_out, 32'd0);
    audio_in_available = 1'b0;
    #1;
    check_eq("mute_drain_empty", {31'd0, read_audio_in}, 32'd0);
    audio_in_available = 1'b1;
    #1;
    check_eq("mute_drain_avail", {31'd0, read_audio_in}, 32'd1);

    // Gated with tone low passes input; tone-only with tone low gives -AMPLITUDE.
    left_channel_audio_in = 32'hCAFE0001;
    right_channel_audio_in = 32'hBEEF0002;
    next_write(2'b01);
    check_eq("gated_lo_left", left_channel_audio_out, 32'hCAFE0001);
    check_eq("gated_lo_right", right_channel_audio_out, 32'hBEEF0002);
    audio_in_available = 1'b0;
    next_write(2'b10);
    check_eq("tone_lo_left", left_channel_audio_out, AmpNeg);
    check_eq("tone_lo_right", right_channel_audio_out, AmpNeg);
    check_eq("tone_no_drain", {31'd0, read_audio_in}, 32'd0);
    audio_in_available = 1'b1;

    // Tone counter past 35768 under period_sel=15, then drop to 1: toggle next edge.
    while (cyc - rel_cyc < 35800) tick(1);
    check_eq("tone_before_switch", {31'd0, tone_level}, 32'd0);
    period_sel = 4'd1;
    tick(1);
    toggle_cyc = cyc;
    check_eq("tone_after_switch", {31'd0, tone_level}, 32'd1);
    next_write(2'b10);
    check_eq("tone_hi_left", left_channel_audio_out, Amp);
    check_eq("tone_hi_right", right_channel_audio_out, Amp);
    next_write(2'b01);
    check_eq("gated_hi_left", left_channel_audio_out, 32'd0);
    check_eq("gated_hi_right", right_channel_audio_out, 32'd0);

    // Half-period for period_sel=1 is 35768, so the next toggle comes 35769 edges later.
    while (cyc < toggle_cyc + 35768) tick(1);
    check_eq("tone_period_hold", {31'd0, tone_level}, 32'd1);
    tick(1);
    check_eq("tone_period_flip", {31'd0, tone_level}, 32'd0);
    next_write(2'b10);
    check_eq("tone_alt_left", left_channel_audio_out, AmpNeg);

    period_sel = 4'd0;
    tick(1);
    check_eq("tone_off", {31'd0, tone_level}, 32'd0);
    tick(50);
    check_eq("tone_off_held", {31'd0, tone_level}, 32'd0);

    // Run passthrough transfers up to 0xFFFE, then two more to watch the wrap.
    mode = 2'b00;
    audio_out_allowed = 1'b1;
    for (int i = 0; i < 210000 && mon_cnt != 16'hFFFE; i++) tick(1);
    audio_out_allowed = 1'b0;
    check_eq("wrap_reach", {16'd0, mon_cnt}, 32'h0000FFFE);
    check_eq("count_fffe", {16'd0, xfer_count}, 32'h0000FFFE);
    audio_out_allowed = 1'b1;
    wait_write();
    tick(1);
    check_eq("count_ffff", {16'd0, xfer_count}, 32'h0000FFFF);
    wait_write();
    tick(1);
    check_eq("count_wrap", {16'd0, xfer_count}, 32'h00000000);

    // Reset mid-XFER kills the strobes at once, without waiting for an edge.
    wait_write();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_write", {31'd0, write_audio_out}, 32'd0);
    check_eq("rst_mid_read", {31'd0, read_audio_in}, 32'd0);
    check_eq("rst_mid_left", left_channel_audio_out, 32'd0);
    check_eq("rst_mid_count", {16'd0, xfer_count}, 32'd0);
    tick(1);
    resetn = 1'b1;
    tick(1);
    check_eq("rel_edge1_write", {31'd0, write_audio_out}, 32'd0);
    tick(1);
    check_eq("rel_edge2_write", {31'd0, write_audio_out}, 32'd1);
    check_eq("rel_edge2_left", left_channel_audio_out, 32'hCAFE0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
